// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared widths and state encodings for the calculator multiplier
//             and its requester arbiter.
//  Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam int ANCHO_OP   = 16;
    localparam int ANCHO_PROD = 32;
    localparam int ANCHO_PASO = $clog2(ANCHO_OP);

    typedef enum logic [1:0] {
        LIBRE     = 2'd0,
        ARRANCAR  = 2'd1,
        ESPERAR   = 2'd2,
        RESPONDER = 2'd3
    } estado_arb_t;

    typedef enum logic [1:0] {
        M_REPOSO = 2'd0,
        M_SUMAR  = 2'd1,
        M_FIN    = 2'd2
    } estado_mul_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/multiplicador.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador
//  Purpose  : Unsigned 16x16 shift-add multiplier, one partial product per
//             cycle, with an iniciar/terminado handshake.
//  Revision : 1.0
// ============================================================================
module multiplicador
    import calc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iniciar,
    input  logic [ANCHO_OP-1:0]   operando_a,
    input  logic [ANCHO_OP-1:0]   operando_b,
    output logic [ANCHO_PROD-1:0] producto,
    output logic                  terminado
);

    estado_mul_t             r_estado;
    logic [ANCHO_PASO-1:0]   r_paso;
    logic [ANCHO_OP-1:0]     r_b;
    logic [ANCHO_PROD-1:0]   r_acum;
    logic [ANCHO_PROD-1:0]   r_producto;
    logic                    r_terminado;
    logic [ANCHO_PROD-1:0]   w_sumando;

    // operando_a is read live each step; the owner keeps it stable.
    assign w_sumando = ANCHO_PROD'(operando_a) << r_paso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= M_REPOSO;
            r_paso      <= '0;
            r_b         <= '0;
            r_acum      <= '0;
            r_producto  <= '0;
            r_terminado <= 1'b0;
        end else begin
            case (r_estado)
                M_REPOSO: begin
                    if (iniciar) begin
                        r_acum      <= '0;
                        r_b         <= operando_b;
                        r_paso      <= '0;
                        r_terminado <= 1'b0;
                        r_estado    <= M_SUMAR;
                    end
                end
                M_SUMAR: begin
                    if (r_b[0]) begin
                        r_acum <= r_acum + w_sumando;
                    end
                    r_b    <= r_b >> 1;
                    r_paso <= r_paso + 1'b1;
                    if (r_paso == ANCHO_PASO'(ANCHO_OP - 1)) begin
                        r_estado <= M_FIN;
                    end
                end
                M_FIN: begin
                    r_producto  <= r_acum;
                    r_terminado <= 1'b1;
                    r_estado    <= M_REPOSO;
                end
                default: r_estado <= M_REPOSO;
            endcase
        end
    end

    assign producto  = r_producto;
    assign terminado = r_terminado;

endmodule : multiplicador
`default_nettype wire

// File: rtl/arbitro_multiplicador.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_multiplicador
//  Purpose  : Round-robin arbiter sharing one multiplicador among several
//             requesters, returning each product through valid/accept.
//  Revision : 1.0
// ============================================================================
module arbitro_multiplicador
    import calc_pkg::*;
#(
    parameter int N_SOLICITANTES = 4,
    parameter int ID_W           = $clog2(N_SOLICITANTES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_SOLICITANTES-1:0]          sol_valido,
    input  logic [N_SOLICITANTES*ANCHO_OP-1:0] sol_a,
    input  logic [N_SOLICITANTES*ANCHO_OP-1:0] sol_b,
    output logic [N_SOLICITANTES-1:0]          sol_listo,
    output logic [N_SOLICITANTES-1:0]          resp_valido,
    output logic [ANCHO_PROD-1:0]              resp_producto,
    input  logic [N_SOLICITANTES-1:0]          resp_acepta,
    output logic                               ocupado,
    output logic [ID_W-1:0]                    id_activo
);

    localparam logic [N_SOLICITANTES-1:0] C_UNO = {{(N_SOLICITANTES-1){1'b0}}, 1'b1};

    estado_arb_t             r_estado;
    logic [ID_W-1:0]         r_ultimo;
    logic [ID_W-1:0]         r_id;
    logic [ANCHO_OP-1:0]     r_a;
    logic [ANCHO_OP-1:0]     r_b;
    logic                    r_iniciar;
    logic [N_SOLICITANTES-1:0] r_resp_valido;
    logic [ANCHO_PROD-1:0]   r_resp_producto;
    logic                    r_ocupado;

    logic                    w_hay;
    logic                    w_acepta;
    logic [ID_W-1:0]         w_grant;
    logic [ANCHO_OP-1:0]     w_a;
    logic [ANCHO_OP-1:0]     w_b;
    logic [ANCHO_PROD-1:0]   w_producto;
    logic                    w_terminado;

    // First set request after 'ultimo', wrapping modulo N.
    function automatic logic [ID_W-1:0] f_siguiente(
        input logic [N_SOLICITANTES-1:0] valido,
        input logic [ID_W-1:0]           ultimo
    );
        logic [ID_W-1:0] w_sel;
        logic            w_hallado;
        int              w_idx;
        w_sel     = ultimo;
        w_hallado = 1'b0;
        for (int k = 1; k <= N_SOLICITANTES; k++) begin
            w_idx = (int'(ultimo) + k) % N_SOLICITANTES;
            if (!w_hallado && valido[ID_W'(w_idx)]) begin
                w_sel     = ID_W'(w_idx);
                w_hallado = 1'b1;
            end
        end
        return w_sel;
    endfunction

    always_comb begin
        w_hay    = |sol_valido;
        w_grant  = f_siguiente(sol_valido, r_ultimo);
        w_acepta = (r_estado == LIBRE) && w_hay;
        w_a      = '0;
        w_b      = '0;
        for (int i = 0; i < N_SOLICITANTES; i++) begin
            if (ID_W'(i) == w_grant) begin
                w_a = sol_a[i*ANCHO_OP +: ANCHO_OP];
                w_b = sol_b[i*ANCHO_OP +: ANCHO_OP];
            end
        end
        sol_listo = w_acepta ? (C_UNO << w_grant) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado        <= LIBRE;
            r_ultimo        <= ID_W'(N_SOLICITANTES - 1);
            r_id            <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_iniciar       <= 1'b0;
            r_resp_valido   <= '0;
            r_resp_producto <= '0;
            r_ocupado       <= 1'b0;
        end else begin
            case (r_estado)
                LIBRE: begin
                    if (w_acepta) begin
                        r_a       <= w_a;
                        r_b       <= w_b;
                        r_id      <= w_grant;
                        r_ultimo  <= w_grant;
                        r_ocupado <= 1'b1;
                        // A zero operand needs no multiplication at all.
                        if (w_a == '0 || w_b == '0) begin
                            r_resp_producto <= '0;
                            r_resp_valido   <= C_UNO << w_grant;
                            r_estado        <= RESPONDER;
                        end else begin
                            r_iniciar <= 1'b1;
                            r_estado  <= ARRANCAR;
                        end
                    end
                end
                ARRANCAR: begin
                    // terminado may still be high from the previous product.
                    r_iniciar <= 1'b0;
                    r_estado  <= ESPERAR;
                end
                ESPERAR: begin
                    if (w_terminado) begin
                        r_resp_producto <= w_producto;
                        r_resp_valido   <= C_UNO << r_id;
                        r_estado        <= RESPONDER;
                    end
                end
                RESPONDER: begin
                    if (resp_acepta[r_id]) begin
                        r_resp_valido <= '0;
                        r_ocupado     <= 1'b0;
                        r_estado      <= LIBRE;
                    end
                end
                default: r_estado <= LIBRE;
            endcase
        end
    end

    multiplicador u_multiplicador (
        .clk        (clk),
        .rst_n      (rst_n),
        .iniciar    (r_iniciar),
        .operando_a (r_a),
        .operando_b (r_b),
        .producto   (w_producto),
        .terminado  (w_terminado)
    );

    assign resp_valido   = r_resp_valido;
    assign resp_producto = r_resp_producto;
    assign ocupado       = r_ocupado;
    assign id_activo     = r_id;

endmodule : arbitro_multiplicador
`default_nettype wire

// File: doc/arbitro_multiplicador.md
# arbitro_multiplicador

Shares the calculator's single 16×16 shift-add multiplier (`multiplicador`) among `N_SOLICITANTES` requesters. Each request is granted round-robin and its operands are latched. The block sequences the multiplier's `iniciar`/`terminado` handshake, and the 32-bit product is returned to the granted requester through a valid/accept handshake. It sits between the calculator's operation units (ALU front end, display formatter, etc.) and the multiplier instance it owns.

## Interface
Parameters:
- `N_SOLICITANTES`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_SOLICITANTES)`: width of the requester index.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low. Must be held low across at least one `clk` rising edge so the internal `multiplicador` also resets.
- `sol_valido`  in  N: request pending, one bit per requester. Must stay high with stable operands until accepted.
- `sol_a`, `sol_b`  in  N×16: operands per requester.
- `sol_listo`  out  N: one-hot accept. The request is taken on an edge where `sol_valido[i] && sol_listo[i]`.
- `resp_valido`  out  N: one-hot result valid for the owning requester.
- `resp_producto`  out  32: shared product bus. Meaningful only while some `resp_valido` bit is set.
- `resp_acepta`  in  N: requester consumes the result on an edge where `resp_valido[i] && resp_acepta[i]`.
- `ocupado`  out  1: high in every state except LIBRE.
- `id_activo`  out  ID_W: index of the requester currently owning the multiplier.

## Operation
- States: LIBRE, ARRANCAR, ESPERAR, RESPONDER.
- LIBRE
  - Compute the grant from the `sol_valido` bits. Search starts at `ultimo+1` and wraps modulo N. The first set bit wins.
  - `sol_listo[grant]=1` combinationally only in LIBRE and only when some `sol_valido` bit is set.
  - On acceptance, latch `a`, `b` and `id`, and set `ultimo<=id`.
  - If `a==0` or `b==0`: set `resp_producto<=0` and go to RESPONDER (zero shortcut; multiplier untouched).
  - Otherwise go to ARRANCAR.
- ARRANCAR
  - Drive `iniciar=1` for exactly this one cycle, with the latched operands on the multiplier inputs.
  - Ignore `terminado` in this cycle, since it may still be high from the previous operation.
  - Unconditionally go to ESPERAR.
- ESPERAR
  - Keep `iniciar=0`. The latched `a`/`b` stay on the multiplier, which reads `operando_a` during every accumulate step.
  - When `terminado==1`, capture the multiplier's `producto` into `resp_producto` and go to RESPONDER.
- RESPONDER
  - Hold `resp_valido[id]=1` and `resp_producto` stable until `resp_acepta[id]`, then go to LIBRE.
  - `resp_acepta` bits of other requesters are ignored.
- Arithmetic: unsigned 16×16→32, no truncation. 0xFFFF×0xFFFF = 0xFFFE0001.
- Round-robin pointer `ultimo` resets to N-1, so requester 0 has first priority after reset.
- The pointer advances only on acceptance, never on requests that are not granted.
- `id_activo` holds the last latched id; it is unchanged in LIBRE.

## Timing
- Reset values: `sol_listo=0`, `resp_valido=0`, `resp_producto=0`, `ocupado=0`, `id_activo=0`, state LIBRE, `ultimo=N-1`.
- Reset mid-operation: all of the above immediately. Any in-flight result is discarded and no `resp_valido` is issued.
- Normal latency, counting the acceptance cycle as cycle 0:
  - `iniciar` is high in cycle 1.
  - `terminado` is first seen in cycle 19.
  - `resp_valido` is high from cycle 20.
- Zero-shortcut latency: `resp_valido` high from cycle 1.
- Turnaround: if `resp_acepta` is high in cycle k, the state is LIBRE in cycle k+1 and the next acceptance is possible in cycle k+1.
- Only one request is accepted per LIBRE cycle. The arbiter holds at most one operation in flight; no queueing.
- Simultaneous requests from all N requesters are granted in strict rotation, one at a time.
- A `sol_valido` that drops before acceptance is legal and simply loses arbitration; no state change results.

## Structure
- Package `calc_pkg`:
  - `ANCHO_OP=16`, `ANCHO_PROD=32`.
  - typedef `estado_arb_t` (enum of the four states).
- Sub-module: one instance of the existing `multiplicador`, with `clk`/`rst_n` wired straight through.
- Round-robin selection is a local combinational function; no separate module.

## Test plan
- Reset, then requester 0 sends 3×5: `sol_listo[0]` in cycle 0; `resp_valido[0]` from cycle 20 with `resp_producto=15`; accept, then `ocupado=0` next cycle.
- All 4 requesters hold requests, each with its own distinct operands (all non-zero): grant order 0,1,2,3,0, and each response carries its own product.
- Requester 2 sends 0x1234×0 and then immediately 0x0000×0xFFFF: each gets `resp_valido[2]` in cycle 1 with product 0, and `iniciar` never pulses.
- Requester 1 sends 0xFFFF×0xFFFF while `resp_acepta` is held low for 10 extra cycles: `resp_producto=0xFFFE0001` stays stable throughout, and no new grant is issued in that period.
- Two back-to-back operations, 7×9 then 2×2: the second result is 4, not a stale `terminado` from the first operation.
- Assert `rst_n=0` in cycle 8 of an operation, then release: all outputs return to reset values, and a fresh 6×7 afterwards returns 42 at the normal latency.
